// File: rtl/dual_port_ram_be_if.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be_if
//
// Bundles the two access ports (A and B) and the status outputs of
// dual_port_ram_be into one interface. The clock and reset are kept out of
// the bundle and stay as plain ports on the RAM.
//
// Signals (NB = DATA_WIDTH / BYTE_WIDTH):
//   en_a, en_b                 access request per port
//   we_a, we_b      [NB]       per-byte write enable (all zero = read)
//   addr_a, addr_b  [ADDR_WIDTH] word address
//   din_a, din_b    [DATA_WIDTH] write data
//   dout_a, dout_b  [DATA_WIDTH] read data (held until the next read)
//   dout_valid_a/b             one-cycle strobe qualifying dout
//   init_busy                  high while the post-reset zero-clear runs
//   coll_pulse                 one-cycle strobe on a write-write collision
//   coll_cnt        [16]       saturating collision count
//
// Modports:
//   master - the side issuing accesses (drives requests, observes results)
//   slave  - the RAM itself
// -----------------------------------------------------------------------------
interface dual_port_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en_a;
    logic [NB-1:0]         we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  dout_valid_a;

    logic                  en_b;
    logic [NB-1:0]         we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  dout_valid_b;

    logic                  init_busy;
    logic                  coll_pulse;
    logic [15:0]           coll_cnt;

    modport master (
        output en_a, we_a, addr_a, din_a,
        output en_b, we_b, addr_b, din_b,
        input  dout_a, dout_valid_a, dout_b, dout_valid_b,
        input  init_busy, coll_pulse, coll_cnt
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a,
        input  en_b, we_b, addr_b, din_b,
        output dout_a, dout_valid_a, dout_b, dout_valid_b,
        output init_busy, coll_pulse, coll_cnt
    );
endinterface

// File: rtl/dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be
//
// True dual-port synchronous RAM with per-byte write enables, a selectable
// cross-port read-during-write policy, deterministic write-write collision
// resolution (port A wins shared lanes) with a saturating collision counter,
// an automatic zero-clear of the whole array after reset, and read-valid
// strobes.
//
// Parameters:
//   DATA_WIDTH  word width (multiple of BYTE_WIDTH)
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH
//   BYTE_WIDTH  bits per write-enable lane
//   RDW_MODE    0 = cross-port reader sees old word, 1 = merged new word
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dual_port_ram_be_if.slave (both access ports + status)
//
// Optional feature (macro DPRAM_OUT_REG_EN): adds a second output register
// stage on dout_a/b and dout_valid_a/b, making read latency 2 cycles.
// -----------------------------------------------------------------------------
module dual_port_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    dual_port_ram_be_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  init_busy_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  ready;
    logic                  rd_a, wr_a, rd_b, wr_b;
    logic                  same_addr, coll;
    logic [NB-1:0]         lane_a, lane_b;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
    logic [DATA_WIDTH-1:0] dout_b_q, dout_b_d;
    logic                  valid_a_q, valid_a_d;
    logic                  valid_b_q, valid_b_d;
    logic                  coll_pulse_q, coll_pulse_d;
    logic [15:0]           coll_cnt_q, coll_cnt_d;

    // -------------------------------------------------------------------------
    // Clear sequencer: walks ptr over every word once, then parks in READY
    // until the next reset.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q     <= ST_READY;
                        init_busy_q <= 1'b0;
                    end
                end
                default: state_q <= ST_READY;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Access decode. Requests are ignored until the clear has finished.
    // -------------------------------------------------------------------------
    assign ready     = (state_q == ST_READY);
    assign rd_a      = ready && bus.en_a && (bus.we_a == '0);
    assign wr_a      = ready && bus.en_a && (bus.we_a != '0);
    assign rd_b      = ready && bus.en_b && (bus.we_b == '0);
    assign wr_b      = ready && bus.en_b && (bus.we_b != '0);
    assign same_addr = (bus.addr_a == bus.addr_b);
    assign coll      = wr_a && wr_b && same_addr;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lane_a  = '0;
        lane_b  = '0;
        rdata_a = mem_q[bus.addr_a];
        rdata_b = mem_q[bus.addr_b];
        for (int i = 0; i < NB; i++) begin
            lane_a[i] = wr_a && bus.we_a[i];
            // B only owns a lane that A is not also writing at the same word.
            lane_b[i] = wr_b && bus.we_b[i] && !(same_addr && lane_a[i]);
            if (RDW_MODE == 1 && same_addr) begin
                // Write-first: forward the other port's written lanes.
                if (rd_a && lane_b[i])
                    rdata_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (rd_b && lane_a[i])
                    rdata_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        dout_a_d     = rd_a ? rdata_a : dout_a_q;
        dout_b_d     = rd_b ? rdata_b : dout_b_q;
        valid_a_d    = rd_a;
        valid_b_d    = rd_b;
        coll_pulse_d = coll;
        coll_cnt_d   = coll_cnt_q;
        if (coll && coll_cnt_q != 16'hFFFF)
            coll_cnt_d = coll_cnt_q + 16'd1;
    end

    // -------------------------------------------------------------------------
    // Storage array. Lanes of A and B never overlap by construction, so the
    // two write ports cannot both target the same bits.
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch so it maps onto RAM macros; its
    // contents are zeroed by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!ready) begin
                mem_q[ptr_q] <= '0;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (lane_a[i])
                        mem_q[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                    if (lane_b[i])
                        mem_q[bus.addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read data, valid strobes and collision status registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q     <= '0;
            dout_b_q     <= '0;
            valid_a_q    <= 1'b0;
            valid_b_q    <= 1'b0;
            coll_pulse_q <= 1'b0;
            coll_cnt_q   <= '0;
        end else begin
            dout_a_q     <= dout_a_d;
            dout_b_q     <= dout_b_d;
            valid_a_q    <= valid_a_d;
            valid_b_q    <= valid_b_d;
            coll_pulse_q <= coll_pulse_d;
            coll_cnt_q   <= coll_cnt_d;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] dout_a_r_q, dout_b_r_q;
    logic                  valid_a_r_q, valid_b_r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_r_q  <= '0;
            dout_b_r_q  <= '0;
            valid_a_r_q <= 1'b0;
            valid_b_r_q <= 1'b0;
        end else begin
            dout_a_r_q  <= dout_a_q;
            dout_b_r_q  <= dout_b_q;
            valid_a_r_q <= valid_a_q;
            valid_b_r_q <= valid_b_q;
        end
    end

    assign bus.dout_a       = dout_a_r_q;
    assign bus.dout_b       = dout_b_r_q;
    assign bus.dout_valid_a = valid_a_r_q;
    assign bus.dout_valid_b = valid_b_r_q;
`else
    assign bus.dout_a       = dout_a_q;
    assign bus.dout_b       = dout_b_q;
    assign bus.dout_valid_a = valid_a_q;
    assign bus.dout_valid_b = valid_b_q;
`endif

    assign bus.init_busy  = init_busy_q;
    assign bus.coll_pulse = coll_pulse_q;
    assign bus.coll_cnt   = coll_cnt_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dual_port_ram_be
//
// Bench for dual_port_ram_be. Expected behaviour comes from a word-array
// reference model: reads return the stored word (or the merged word for the
// write-first policy), writes merge enabled bytes with port A applied last,
// and output latency is modelled as a short delay line.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_be;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = 8;
    localparam int NB    = DW / BW;
    localparam int DEPTH = 2 ** AW;
    localparam int RDW   = 0;
`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus ();

    dual_port_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .RDW_MODE(RDW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear;
    logic [DW-1:0] m_s1a, m_s1b, m_s2a, m_s2b;
    bit            m_v1a, m_v1b, m_v2a, m_v2b;
    bit            m_coll;
    int            m_cnt;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] we);
        logic [DW-1:0] r = old_w;
        for (int i = 0; i < NB; i++)
            if (we[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_da(); return (LAT == 2) ? m_s2a : m_s1a; endfunction
    function automatic logic [DW-1:0] exp_db(); return (LAT == 2) ? m_s2b : m_s1b; endfunction
    function automatic bit exp_va(); return (LAT == 2) ? m_v2a : m_v1a; endfunction
    function automatic bit exp_vb(); return (LAT == 2) ? m_v2b : m_v1b; endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_clear = 0;
        m_s1a = '0; m_s1b = '0; m_s2a = '0; m_s2b = '0;
        m_v1a = 0;  m_v1b = 0;  m_v2a = 0;  m_v2b = 0;
        m_coll = 0; m_cnt = 0;
    endtask

    // Applies the currently driven inputs for one clock edge to both model
    // and DUT; returns at the sampling point 1 ns after the edge.
    task automatic step();
        logic [DW-1:0] ra, rb;
        bit rd_a, rd_b, wr_a, wr_b;
        m_s2a = m_s1a; m_s2b = m_s1b; m_v2a = m_v1a; m_v2b = m_v1b;
        m_v1a = 0; m_v1b = 0; m_coll = 0;
        if (m_clear >= DEPTH) begin
            rd_a = bus.en_a && (bus.we_a == 0);
            wr_a = bus.en_a && (bus.we_a != 0);
            rd_b = bus.en_b && (bus.we_b == 0);
            wr_b = bus.en_b && (bus.we_b != 0);
            ra = m_mem[bus.addr_a];
            rb = m_mem[bus.addr_b];
            if (RDW == 1 && bus.addr_a == bus.addr_b) begin
                if (rd_a && wr_b) ra = merge(ra, bus.din_b, bus.we_b);
                if (rd_b && wr_a) rb = merge(rb, bus.din_a, bus.we_a);
            end
            if (wr_b) m_mem[bus.addr_b] = merge(m_mem[bus.addr_b], bus.din_b, bus.we_b);
            if (wr_a) m_mem[bus.addr_a] = merge(m_mem[bus.addr_a], bus.din_a, bus.we_a);
            if (wr_a && wr_b && bus.addr_a == bus.addr_b) begin
                m_coll = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (rd_a) begin m_s1a = ra; m_v1a = 1; end
            if (rd_b) begin m_s1b = rb; m_v1b = 1; end
        end else begin
            m_clear++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.en_a = 0; bus.we_a = '0; bus.addr_a = '0; bus.din_a = '0;
        bus.en_b = 0; bus.we_b = '0; bus.addr_b = '0; bus.din_b = '0;
    endtask

    task automatic drive_a(input bit en, input logic [NB-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        bus.en_a = en; bus.we_a = we; bus.addr_a = addr; bus.din_a = din;
    endtask

    task automatic drive_b(input bit en, input logic [NB-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        bus.en_b = en; bus.we_b = we; bus.addr_b = addr; bus.din_b = din;
    endtask

    task automatic drive_random(input int max_addr);
        drive_a($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0,
                AW'($urandom_range(0, max_addr)), $urandom);
        drive_b($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0,
                AW'($urandom_range(0, max_addr)), $urandom);
    endtask

    // Asserts reset away from any clock edge and resets the model.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    // Releases reset at a sampling point and steps while init_busy is high,
    // with random (ignored) requests, up to max_edges edges.
    task automatic release_and_clear(input int max_edges, output int edges);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
        while (bus.init_busy === 1'b1 && edges < max_edges) begin
            drive_random(DEPTH - 1);
            step();
            edges++;
        end
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int edges;
        idle();
        model_reset();
        #12;
        n_tests++;
        if (bus.init_busy !== 1'b1 || bus.dout_a !== '0 || bus.dout_b !== '0 ||
            bus.dout_valid_a !== 1'b0 || bus.dout_valid_b !== 1'b0 ||
            bus.coll_pulse !== 1'b0 || bus.coll_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b da=%h db=%h va=%b vb=%b cp=%b cc=%h, required busy=1 and all else 0",
                     bus.init_busy, bus.dout_a, bus.dout_b, bus.dout_valid_a,
                     bus.dout_valid_b, bus.coll_pulse, bus.coll_cnt);
        end
        release_and_clear(64, edges);
        n_tests++;
        if (edges != DEPTH) begin
            n_fail++;
            $display("FAIL clear_duration: busy edges=%0d, required %0d", edges, DEPTH);
        end
        n_tests++;
        if (bus.init_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drop: init_busy=%b, required 0", bus.init_busy);
        end
    endtask

    task automatic test_clear();
        int nvalid = 0;
        for (int k = 0; k < DEPTH + LAT; k++) begin
            if (k < DEPTH) drive_a(1, '0, AW'(k), '0); else idle();
            step();
            if (bus.dout_valid_a === 1'b1) nvalid++;
            n_tests++;
            if (bus.dout_a !== exp_da() || bus.dout_valid_a !== exp_va()) begin
                n_fail++;
                $display("FAIL clear_read[%0d]: dout_a=%h valid=%b, required %h valid=%b",
                         k, bus.dout_a, bus.dout_valid_a, exp_da(), exp_va());
            end
        end
        n_tests++;
        if (nvalid != DEPTH) begin
            n_fail++;
            $display("FAIL clear_valid_count: %0d strobes, required %0d", nvalid, DEPTH);
        end
    endtask

    task automatic test_byte_enables();
        drive_a(1, 4'b1111, 4'd3, 32'hDEADBEEF); step(); idle();
        drive_b(1, 4'b0101, 4'd3, 32'h11223344); step(); idle();
        drive_b(1, 4'b0000, 4'd3, 32'h0);        step(); idle();
        for (int i = 1; i < LAT; i++) step();
        n_tests++;
        if (bus.dout_b !== 32'hDE22BE44 || bus.dout_valid_b !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_enables: dout_b=%h valid=%b, required DE22BE44 valid=1",
                     bus.dout_b, bus.dout_valid_b);
        end
    endtask

    task automatic test_rdw();
        logic [DW-1:0] want;
        want = (RDW == 1) ? 32'h12345678 : 32'hAAAA0000;
        drive_a(1, 4'b1111, 4'd5, 32'hAAAA0000); step(); idle();
        drive_a(1, 4'b0000, 4'd5, 32'h0);
        drive_b(1, 4'b1111, 4'd5, 32'h12345678); step(); idle();
        for (int i = 1; i < LAT; i++) step();
        n_tests++;
        if (bus.dout_a !== want || bus.dout_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rdw_cross: dout_a=%h valid=%b, required %h valid=1",
                     bus.dout_a, bus.dout_valid_a, want);
        end
        drive_b(1, 4'b0000, 4'd5, 32'h0); step(); idle();
        for (int i = 1; i < LAT; i++) step();
        n_tests++;
        if (bus.dout_b !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rdw_after: dout_b=%h, required 12345678", bus.dout_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        for (int i = 0; i < 3; i++) begin
            vals[i] = $urandom;
            drive_b(1, 4'b1111, AW'(i + 1), vals[i]);
            step();
        end
        idle();
        for (int k = 0; k < 3 + LAT; k++) begin
            bit want_v;
            if (k < 3) drive_b(1, '0, AW'(k + 1), '0); else idle();
            step();
            want_v = (k >= LAT - 1) && (k - (LAT - 1) < 3);
            n_tests++;
            if (bus.dout_valid_b !== want_v ||
                (want_v && bus.dout_b !== vals[k - (LAT - 1)])) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: valid_b=%b dout_b=%h, required valid=%b data=%h",
                         k, bus.dout_valid_b, bus.dout_b, want_v,
                         want_v ? vals[k - (LAT - 1)] : 32'h0);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive_random(3);
            step();
            n_tests++;
            if (bus.dout_a !== exp_da() || bus.dout_valid_a !== exp_va() ||
                bus.dout_b !== exp_db() || bus.dout_valid_b !== exp_vb() ||
                bus.coll_pulse !== m_coll || bus.coll_cnt !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL random[%0d]: da=%h va=%b db=%h vb=%b cp=%b cc=%h, required da=%h va=%b db=%h vb=%b cp=%b cc=%h",
                         k, bus.dout_a, bus.dout_valid_a, bus.dout_b, bus.dout_valid_b,
                         bus.coll_pulse, bus.coll_cnt, exp_da(), exp_va(), exp_db(),
                         exp_vb(), m_coll, 16'(m_cnt));
            end
        end
        idle();
    endtask

    task automatic test_collision();
        int edges;
        apply_reset();
        release_and_clear(64, edges);
        drive_a(1, 4'b0011, 4'd7, 32'hFFFFFFFF);
        drive_b(1, 4'b1111, 4'd7, 32'h00000000);
        step();
        idle();
        n_tests++;
        if (bus.coll_pulse !== 1'b1 || bus.coll_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL collision_first: coll_pulse=%b coll_cnt=%h, required 1 and 0001",
                     bus.coll_pulse, bus.coll_cnt);
        end
        drive_a(1, '0, 4'd7, '0); step(); idle();
        n_tests++;
        if (bus.coll_pulse !== 1'b0 || bus.coll_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL collision_pulse_len: coll_pulse=%b coll_cnt=%h, required 0 and 0001",
                     bus.coll_pulse, bus.coll_cnt);
        end
        for (int i = 1; i < LAT; i++) step();
        n_tests++;
        if (bus.dout_a !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL collision_merge: mem[7]=%h, required 0000FFFF", bus.dout_a);
        end
        for (int k = 0; k < 70000; k++) begin
            drive_a(1, 4'b0011, 4'd7, 32'hFFFFFFFF);
            drive_b(1, 4'b1111, 4'd7, 32'h00000000);
            step();
        end
        idle();
        n_tests++;
        if (bus.coll_cnt !== 16'hFFFF || bus.coll_cnt !== 16'(m_cnt)) begin
            n_fail++;
            $display("FAIL collision_saturate: coll_cnt=%h, required FFFF", bus.coll_cnt);
        end
        step();
        n_tests++;
        if (bus.coll_pulse !== 1'b0 || bus.coll_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL collision_hold: coll_pulse=%b coll_cnt=%h, required 0 and FFFF",
                     bus.coll_pulse, bus.coll_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        for (int k = 0; k < 6; k++) begin
            drive_a(1, '0, AW'(k), '0);
            drive_b(1, 4'b1111, AW'(k + 8), $urandom);
            step();
        end
        apply_reset();
        n_tests++;
        if (bus.init_busy !== 1'b1 || bus.dout_a !== '0 || bus.dout_b !== '0 ||
            bus.dout_valid_a !== 1'b0 || bus.dout_valid_b !== 1'b0 ||
            bus.coll_pulse !== 1'b0 || bus.coll_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ready: busy=%b da=%h db=%h va=%b vb=%b cp=%b cc=%h, required busy=1 and all else 0",
                     bus.init_busy, bus.dout_a, bus.dout_b, bus.dout_valid_a,
                     bus.dout_valid_b, bus.coll_pulse, bus.coll_cnt);
        end
        release_and_clear(8, edges);
        n_tests++;
        if (edges != 8 || bus.init_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_clear: edges=%0d busy=%b, required 8 and 1", edges, bus.init_busy);
        end
        apply_reset();
        release_and_clear(64, edges);
        n_tests++;
        if (edges != DEPTH) begin
            n_fail++;
            $display("FAIL restart_clear: busy edges=%0d, required %0d", edges, DEPTH);
        end
        for (int k = 0; k < DEPTH + LAT; k++) begin
            if (k < DEPTH) drive_b(1, '0, AW'(k), '0); else idle();
            step();
            n_tests++;
            if (bus.dout_b !== exp_db() || bus.dout_valid_b !== exp_vb()) begin
                n_fail++;
                $display("FAIL reclear_read[%0d]: dout_b=%h valid=%b, required %h valid=%b",
                         k, bus.dout_b, bus.dout_valid_b, exp_db(), exp_vb());
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clear();
        test_byte_enables();
        test_rdw();
        test_back_to_back();
        test_random();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
